// File: rtl/tetris_vga_pkg.sv
// Shared types and constants for the Tetris VGA display path.
// Palette table exists only when TETRIS_VRAM_WRITER_PALETTE_INIT_EN is defined.
package tetris_vga_pkg;

  localparam int BOARD_W   = 10;
  localparam int BOARD_H   = 20;
  localparam int PAL_WORDS = 16;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LOAD,
    WRITE,
    DONE
`ifdef TETRIS_VRAM_WRITER_PALETTE_INIT_EN
    , PAL_WRITE
`endif
  } wr_state_e;

  // A board cell is a 4-bit palette index carried in the low bits of a 32-bit word.
  typedef logic [3:0] cell_code_t;

  typedef struct packed {
    logic [27:0] rsvd;
    cell_code_t  code;
  } cell_word_t;

`ifdef TETRIS_VRAM_WRITER_PALETTE_INIT_EN
  localparam logic [31:0] PALETTE_DEFAULT [PAL_WORDS] = '{
    32'h000, 32'h0FF, 32'hFF0, 32'hA0F,
    32'h0F0, 32'hF00, 32'h00F, 32'hF80,
    32'h888, 32'hFFF, 32'h444, 32'hCCC,
    32'h08F, 32'hF08, 32'h8F0, 32'h222
  };
`endif

endpackage

// File: rtl/tetris_vram_writer_if.sv
// Write-only Avalon-MM bundle between the VRAM writer (master) and the VGA display slave.
interface tetris_vram_writer_if #(
  parameter int AVL_AW = 12
);

  logic [AVL_AW-1:0] address;
  logic              chipselect;
  logic              write;
  logic [3:0]        byteenable;
  logic [31:0]       writedata;
  logic              waitrequest;

  modport master (
    output address, chipselect, write, byteenable, writedata,
    input  waitrequest
  );

  modport slave (
    input  address, chipselect, write, byteenable, writedata,
    output waitrequest
  );

endinterface

// File: rtl/avm_single_writer.sv
// Single-beat Avalon-MM write: strobes follow go_i and the beat retires on the first edge
// with waitrequest low. The caller keeps addr_i/data_i steady for as long as go_i is high.
module avm_single_writer #(
  parameter int AVL_AW = 12
) (
  input  logic              go_i,
  input  logic [AVL_AW-1:0] addr_i,
  input  logic [31:0]       data_i,
  output logic              ack_o,
  tetris_vram_writer_if.master avm
);

  assign avm.chipselect = go_i;
  assign avm.write      = go_i;
  assign avm.byteenable = go_i ? 4'b1111 : 4'b0000;
  assign avm.address    = go_i ? addr_i : '0;
  assign avm.writedata  = go_i ? data_i : '0;
  assign ack_o          = go_i & ~avm.waitrequest;

endmodule

// File: rtl/tetris_vram_writer.sv
// Copies WORD_COUNT game-state words into the VGA display RAM over Avalon-MM on each start.
// Define TETRIS_VRAM_WRITER_PALETTE_INIT_EN to load PALETTE_DEFAULT at PAL_BASE after reset.
module tetris_vram_writer
  import tetris_vga_pkg::*;
#(
  parameter int WORD_COUNT = BOARD_W * BOARD_H,
  parameter int DST_BASE   = 0,
  parameter int SRC_AW     = 8,
  parameter int AVL_AW     = 12,
  parameter int PAL_BASE   = 240
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              src_rd_o,
  output logic [SRC_AW-1:0] src_addr_o,
  input  logic [31:0]       src_data_i,
  tetris_vram_writer_if.master avm
);

  localparam int              IDX_W    = (WORD_COUNT > 1) ? $clog2(WORD_COUNT) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORD_COUNT - 1);

`ifdef TETRIS_VRAM_WRITER_PALETTE_INIT_EN
  localparam bit PAL_EN = 1'b1;
`else
  localparam bit PAL_EN = 1'b0;
`endif

  if (WORD_COUNT < 1 || DST_BASE + WORD_COUNT > 2**AVL_AW || WORD_COUNT > 2**SRC_AW) begin : g_bad_cfg
    $fatal(1, "tetris_vram_writer: copy window does not fit the source or Avalon address space");
  end

  if (PAL_EN && PAL_BASE + PAL_WORDS > 2**AVL_AW) begin : g_bad_pal
    $fatal(1, "tetris_vram_writer: palette window does not fit the Avalon address space");
  end

  wr_state_e         state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [31:0]       data_q, data_d;

  logic              wr_go;
  logic [AVL_AW-1:0] wr_addr;
  logic [31:0]       wr_data;
  logic              wr_ack;

`ifdef TETRIS_VRAM_WRITER_PALETTE_INIT_EN
  logic [3:0]        pal_idx_q, pal_idx_d;
  logic              pal_pend_q, pal_pend_d;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
    end
  end

`ifdef TETRIS_VRAM_WRITER_PALETTE_INIT_EN
  // Palette init is requested by reset itself and runs once on the way out of IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pal_idx_q  <= '0;
      pal_pend_q <= 1'b1;
    end else begin
      pal_idx_q  <= pal_idx_d;
      pal_pend_q <= pal_pend_d;
    end
  end
`endif

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    data_d  = data_q;
`ifdef TETRIS_VRAM_WRITER_PALETTE_INIT_EN
    pal_idx_d  = pal_idx_q;
    pal_pend_d = pal_pend_q;
`endif
    case (state_q)
      IDLE: begin
`ifdef TETRIS_VRAM_WRITER_PALETTE_INIT_EN
        if (pal_pend_q) begin
          state_d    = PAL_WRITE;
          pal_idx_d  = '0;
          pal_pend_d = 1'b0;
        end else
`endif
        if (start_i) begin
          state_d = FETCH;
          idx_d   = '0;
        end
      end
      FETCH: state_d = LOAD;
      LOAD: begin
        data_d  = src_data_i;
        state_d = WRITE;
      end
      WRITE: begin
        if (wr_ack) begin
          if (idx_q == LAST_IDX) begin
            state_d = DONE;
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            state_d = FETCH;
          end
        end
      end
      DONE: state_d = IDLE;
`ifdef TETRIS_VRAM_WRITER_PALETTE_INIT_EN
      PAL_WRITE: begin
        if (wr_ack) begin
          if (pal_idx_q == 4'(PAL_WORDS - 1)) begin
            state_d = IDLE;
          end else begin
            pal_idx_d = pal_idx_q + 4'd1;
          end
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  // Outputs are pure functions of state so reset clears them without waiting for a clock.
  always_comb begin
    busy_o     = 1'b0;
    done_o     = 1'b0;
    src_rd_o   = 1'b0;
    src_addr_o = '0;
    wr_go      = 1'b0;
    wr_addr    = '0;
    wr_data    = '0;
    case (state_q)
      FETCH: begin
        busy_o     = 1'b1;
        src_rd_o   = 1'b1;
        src_addr_o = SRC_AW'(idx_q);
      end
      LOAD: busy_o = 1'b1;
      WRITE: begin
        busy_o  = 1'b1;
        wr_go   = 1'b1;
        wr_addr = AVL_AW'(DST_BASE) + AVL_AW'(idx_q);
        wr_data = data_q;
      end
      DONE: begin
        busy_o = 1'b1;
        done_o = 1'b1;
      end
`ifdef TETRIS_VRAM_WRITER_PALETTE_INIT_EN
      PAL_WRITE: begin
        busy_o  = 1'b1;
        wr_go   = 1'b1;
        wr_addr = AVL_AW'(PAL_BASE) + AVL_AW'(pal_idx_q);
        wr_data = PALETTE_DEFAULT[pal_idx_q];
      end
`endif
      default: busy_o = 1'b0;
    endcase
  end

  avm_single_writer #(
    .AVL_AW(AVL_AW)
  ) u_writer (
    .go_i   (wr_go),
    .addr_i (wr_addr),
    .data_i (wr_data),
    .ack_o  (wr_ack),
    .avm    (avm)
  );

endmodule

// File: tb/tb_tetris_vram_writer.sv
// Scoreboard bench for tetris_vram_writer: randomized source data and waitrequest stalls,
// expected Avalon writes queued at stimulus time and retired by an independent bus monitor.
`timescale 1ns/1ps
module tb_tetris_vram_writer;
  import tetris_vga_pkg::*;

  localparam int WC         = 4;
  localparam int DST        = 16;
  localparam int SRC_AW     = 8;
  localparam int AVL_AW     = 12;
  localparam int PAL_BASE   = 240;
  localparam int MAX_CYCLES = 400;

  typedef struct {
    logic [AVL_AW-1:0] addr;
    logic [31:0]       data;
  } wr_t;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              startReq;
  logic              busy;
  logic              done;
  logic              srcRd;
  logic [SRC_AW-1:0] srcAddr;
  logic [31:0]       srcData;
  logic [31:0]       srcMem [256];

  wr_t expQ[$];
  int  nChecks = 0;
  int  nFails = 0;
  int  acceptedCount = 0;
  int  doneCount = 0;
  int  stallCount = 0;
  int  stallMode = 0;
  int  stallWord = 0;
  int  stallLeft = 0;

  tetris_vram_writer_if #(.AVL_AW(AVL_AW)) avm ();

  tetris_vram_writer #(
    .WORD_COUNT(WC),
    .DST_BASE  (DST),
    .SRC_AW    (SRC_AW),
    .AVL_AW    (AVL_AW),
    .PAL_BASE  (PAL_BASE)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start_i   (startReq),
    .busy_o    (busy),
    .done_o    (done),
    .src_rd_o  (srcRd),
    .src_addr_o(srcAddr),
    .src_data_i(srcData),
    .avm       (avm)
  );

  // 50 MHz fabric clock
  always #10 clk = ~clk;

  // Source RAM answers one cycle after a read strobe and shows garbage otherwise
  always @(posedge clk) srcData <= srcRd ? srcMem[srcAddr] : $urandom();

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    nChecks++;
    if (actual !== expected) begin
      nFails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic failNow(input string msg);
    nChecks++;
    nFails++;
    $display("[TB] FAIL %s", msg);
  endtask

  // Slave stall generator: none, a fixed stall on one word, or random stalls
  initial begin
    bit wreq;
    avm.waitrequest = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (stallMode)
        1:       wreq = avm.write && (acceptedCount == stallWord) && (stallLeft > 0);
        2:       wreq = ($urandom_range(0, 2) == 0);
        default: wreq = 1'b0;
      endcase
      if (wreq && avm.write) stallCount++;
      if (stallMode == 1 && wreq) stallLeft--;
      avm.waitrequest = wreq;
    end
  end

  // Bus monitor: every strobed cycle must match the head of the expected queue
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1) begin
        if (avm.write || avm.chipselect) begin
          checkOutput("chipselect", avm.chipselect, 1);
          checkOutput("byteenable", avm.byteenable, 4'hF);
          if (expQ.size() == 0) begin
            failNow($sformatf("unexpected write: addr 0x%0h data 0x%0h, none required", avm.address, avm.writedata));
          end else begin
            checkOutput("write addr", avm.address, expQ[0].addr);
            checkOutput("write data", avm.writedata, expQ[0].data);
            if (!avm.waitrequest) begin
              void'(expQ.pop_front());
              acceptedCount++;
            end
          end
        end else begin
          checkOutput("idle bus", {avm.address, avm.byteenable, avm.writedata}, '0);
        end
        if (done) doneCount++;
      end
    end
  end

  task automatic pushCopy(input bit fixedData);
    wr_t w;
    for (int i = 0; i < WC; i++) begin
      srcMem[i] = fixedData ? 32'(10 + i) : $urandom();
      w.addr = AVL_AW'((DST + i) % (1 << AVL_AW));
      w.data = srcMem[i];
      expQ.push_back(w);
    end
  endtask

  task automatic checkResetOutputs(input string name);
    checkOutput(name, {busy, done, srcRd, srcAddr, avm.address, avm.chipselect,
                       avm.write, avm.byteenable, avm.writedata}, '0);
  endtask

`ifdef TETRIS_VRAM_WRITER_PALETTE_INIT_EN
  task automatic paletteInit();
    wr_t w;
    int  cycles = 0;
    int  doneBefore = doneCount;
    for (int k = 0; k < PAL_WORDS; k++) begin
      w.addr = AVL_AW'(PAL_BASE + k);
      w.data = PALETTE_DEFAULT[k];
      expQ.push_back(w);
    end
    forever begin
      @(negedge clk);
      #1;
      cycles++;
      startReq = (cycles == 3);
      if (expQ.size() == 0 || cycles > MAX_CYCLES) break;
      checkOutput("busy during palette init", busy, 1);
    end
    startReq = 1'b0;
    if (expQ.size() != 0) failNow("palette init timeout");
    repeat (3) begin
      @(negedge clk);
      checkOutput("idle after palette init", {busy, srcRd}, 0);
    end
    checkOutput("no done for palette", doneCount - doneBefore, 0);
  endtask
`endif

  task automatic releaseReset();
    rst_n = 1'b1;
`ifdef TETRIS_VRAM_WRITER_PALETTE_INIT_EN
    paletteInit();
`endif
  endtask

  task automatic applyStimulus(input bit fixedData, input int mode, input int stWord,
                               input int stCycles, input bit startNoise);
    int cycles = 0;
    int doneBefore;
    bit seen = 1'b0;
    pushCopy(fixedData);
    stallMode = mode;
    stallWord = stWord;
    stallLeft = stCycles;
    @(negedge clk);
    stallCount = 0;
    doneBefore = doneCount;
    startReq = 1'b1;
    while (!seen && cycles < MAX_CYCLES) begin
      @(negedge clk);
      cycles++;
      startReq = startNoise && (cycles == 5 || cycles == 6);
      if (done) seen = 1'b1;
      else checkOutput("busy during burst", busy, 1);
    end
    startReq = 1'b0;
    if (!seen) begin
      failNow($sformatf("done timeout: no done within %0d cycles", MAX_CYCLES));
    end else begin
      checkOutput("start-to-done latency", cycles, 3 * WC + 1 + stallCount);
      checkOutput("busy in done cycle", busy, 1);
      if (startNoise) startReq = 1'b1;
      @(negedge clk);
      startReq = 1'b0;
      checkOutput("done width", done, 0);
      checkOutput("busy after done", busy, 0);
      repeat (4) begin
        @(negedge clk);
        checkOutput("no restart", {busy, srcRd}, 0);
      end
      checkOutput("writes outstanding", expQ.size(), 0);
      checkOutput("done pulses", doneCount - doneBefore, 1);
    end
    stallMode = 0;
  endtask

  task automatic resetMidBurst();
    int waitCycles = 0;
    pushCopy(1'b0);
    stallMode = 0;
    @(negedge clk);
    startReq = 1'b1;
    @(negedge clk);
    startReq = 1'b0;
    while (!(avm.write && avm.address == AVL_AW'(DST + 1)) && waitCycles < MAX_CYCLES) begin
      @(negedge clk);
      waitCycles++;
    end
    if (waitCycles >= MAX_CYCLES) failNow("word 1 write never presented");
    #3 rst_n = 1'b0;
    #1 checkResetOutputs("outputs at mid-burst reset");
    expQ.delete();
    repeat (2) @(negedge clk);
    checkResetOutputs("outputs held in reset");
    releaseReset();
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) srcMem[i] = $urandom();
    rst_n    = 1'b0;
    startReq = 1'b0;
    repeat (3) @(negedge clk);
    checkResetOutputs("outputs in reset");
    releaseReset();
    repeat (2) @(negedge clk);
    applyStimulus(1'b1, 0, 0, 0, 1'b0);
    applyStimulus(1'b0, 1, 2, 3, 1'b0);
    applyStimulus(1'b0, 0, 0, 0, 1'b1);
    resetMidBurst();
    applyStimulus(1'b0, 0, 0, 0, 1'b0);
    repeat (4) applyStimulus(1'b0, 2, 0, 0, 1'b1);
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
